usrs_ping_sched: RTL

- Schedules the single shared ultrasonic ranger (USRS) between the two FDU strings, A and B.
- Arbitrates ping requests, sequences the trigger pulse, and measures echo width.
- Returns a scaled range result and a done pulse to the granted string.
- Sits between the string controllers and the bidirectional usrs pad; the top level builds the tri-state from usrs_oe and usrs_out.

---
 rtl/usrs_ping_sched.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/usrs_ping_sched.sv
// Shares the single ultrasonic ranger between FDU strings A and B: arbitrates pings,
// drives the trigger pulse, measures echo width. Optional macro USRS_ECHO_SYNC_EN adds a 2-flop echo synchronizer.
module usrs_ping_sched #(
    parameter int TRIGGER_PULSE = 125,
    parameter int ECHO_WAIT_MAX = 1000000,
    parameter int ECHO_MAX      = 1000000,
    parameter int HOLDOFF       = 1500000,
    parameter int CNT_W         = 24,
    parameter int RESULT_SHIFT  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [1:0]  prime,
    output logic [1:0]  gnt,
    output logic [1:0]  done,
    output logic [15:0] result,
    output logic        result_err,
    input  logic        usrs_in,
    output logic        usrs_out,
    output logic        usrs_oe,
    output logic        busy,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_TRIG      = 3'd1,
        ST_TRIG_END  = 3'd2,
        ST_WAIT_ECHO = 3'd3,
        ST_MEASURE   = 3'd4,
        ST_DONE      = 3'd5,
        ST_HOLDOFF   = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] TRIG_LAST  = CNT_W'(TRIGGER_PULSE - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(ECHO_WAIT_MAX - 1);
    localparam logic [CNT_W-1:0] ECHO_LAST  = CNT_W'(ECHO_MAX - 1);
    localparam logic [CNT_W-1:0] ECHO_LIMIT = CNT_W'(ECHO_MAX);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLDOFF - 1);

    function automatic logic [15:0] scale_result(input logic [CNT_W-1:0] count);
        logic [CNT_W-1:0] shifted;
        logic [15:0]      scaled;
        shifted = count >> RESULT_SHIFT;
        if (shifted > CNT_W'(16'hFFFF)) begin
            scaled = 16'hFFFF;
        end else begin
            scaled = shifted[15:0];
        end
        return scaled;
    endfunction

    // last_b = 1 means string B was served last; prime overrides the round robin
    function automatic logic [1:0] pick_grant(input logic [1:0] r, input logic [1:0] p, input logic last_b);
        logic [1:0] pick;
        case (r)
            2'b01:   pick = 2'b01;
            2'b10:   pick = 2'b10;
            2'b11: begin
                case (p)
                    2'b01:   pick = 2'b01;
                    2'b10:   pick = 2'b10;
                    default: pick = last_b ? 2'b01 : 2'b10;
                endcase
            end
            default: pick = 2'b00;
        endcase
        return pick;
    endfunction

    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [1:0]       gnt_r, gnt_s, done_r, done_s;
    logic             last_b_r, last_b_s, err_r, err_s;
    logic [15:0]      result_r, result_s;
    logic             oe_r, oe_s, out_r, out_s, busy_r, busy_s;
    logic             echo_s;

`ifdef USRS_ECHO_SYNC_EN
    logic [1:0] echo_sync_r;
    // Two-flop synchronizer for the asynchronous echo line
    always_ff @(posedge clk) begin
        if (reset) begin
            echo_sync_r <= 2'b00;
        end else begin
            echo_sync_r <= {echo_sync_r[0], usrs_in};
        end
    end
    assign echo_s = echo_sync_r[1];
`else
    assign echo_s = usrs_in;
`endif

    // Next-state, counter and result logic; outputs follow the next state so they are registered
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        gnt_s    = gnt_r;
        last_b_s = last_b_r;
        result_s = result_r;
        err_s    = err_r;
        done_s   = 2'b00;
        case (state_r)
            ST_IDLE: begin
                cnt_s = CNT_ZERO;
                if (req != 2'b00) begin
                    gnt_s   = pick_grant(req, prime, last_b_r);
                    state_s = ST_TRIG;
                end else begin
                    gnt_s = 2'b00;
                end
            end
            ST_TRIG: begin
                if (cnt_r == TRIG_LAST) begin
                    state_s = ST_TRIG_END;
                    cnt_s   = CNT_ZERO;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_TRIG_END: begin
                state_s = ST_WAIT_ECHO;
                cnt_s   = CNT_ZERO;
            end
            ST_WAIT_ECHO: begin
                if (echo_s) begin
                    state_s = ST_MEASURE;
                    cnt_s   = CNT_ONE;
                end else if (cnt_r == WAIT_LAST) begin
                    state_s  = ST_DONE;
                    result_s = scale_result(CNT_ZERO);
                    err_s    = 1'b1;
                    done_s   = gnt_r;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_MEASURE: begin
                if (!echo_s) begin
                    state_s  = ST_DONE;
                    result_s = scale_result(cnt_r);
                    err_s    = 1'b0;
                    done_s   = gnt_r;
                end else if (cnt_r == ECHO_LAST) begin
                    state_s  = ST_DONE;
                    result_s = scale_result(ECHO_LIMIT);
                    err_s    = 1'b1;
                    done_s   = gnt_r;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_DONE: begin
                state_s  = ST_HOLDOFF;
                cnt_s    = CNT_ZERO;
                last_b_s = gnt_r[1];
                gnt_s    = 2'b00;
            end
            ST_HOLDOFF: begin
                if (cnt_r == HOLD_LAST) begin
                    state_s = ST_IDLE;
                    cnt_s   = CNT_ZERO;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = CNT_ZERO;
                gnt_s   = 2'b00;
            end
        endcase
        // The pad is only ever driven in the two trigger states
        oe_s   = (state_s == ST_TRIG) || (state_s == ST_TRIG_END);
        out_s  = (state_s == ST_TRIG);
        busy_s = (state_s != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            cnt_r    <= CNT_ZERO;
            gnt_r    <= 2'b00;
            done_r   <= 2'b00;
            last_b_r <= 1'b1;
            result_r <= 16'h0000;
            err_r    <= 1'b0;
            oe_r     <= 1'b0;
            out_r    <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            gnt_r    <= gnt_s;
            done_r   <= done_s;
            last_b_r <= last_b_s;
            result_r <= result_s;
            err_r    <= err_s;
            oe_r     <= oe_s;
            out_r    <= out_s;
            busy_r   <= busy_s;
        end
    end

    assign gnt        = gnt_r;
    assign done       = done_r;
    assign result     = result_r;
    assign result_err = err_r;
    assign usrs_oe    = oe_r;
    assign usrs_out   = out_r;
    assign busy       = busy_r;
    assign state_dbg  = state_r;

endmodule
